// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: packs little-endian bytes into 32-bit words and issues one init write per word.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running mod-2^32 session checksum output.
module imem_loader #(
    parameter int WORD_COUNT = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              init_en_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic [31:0]       init_data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic [31:0]       idata_q, idata_d;
    logic              start_ok;

    // start is only honoured when no session is running
    assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = COLLECT;
                    addr_d  = '0;
                    idx_d   = '0;
                    word_d  = '0;
                end
            end
            COLLECT: begin
                if (rx_valid_i) begin
                    word_d[idx_q*8 +: 8] = rx_data_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                        iaddr_d = addr_q;
                        idata_d = {rx_data_i, word_q[23:0]};
                    end
                end
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            iaddr_q <= '0;
            idata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
        end
    end

    assign rx_ready_o  = (state_q == COLLECT);
    assign init_en_o   = (state_q == WRITE);
    assign busy_o      = (state_q == COLLECT) || (state_q == WRITE);
    assign done_o      = (state_q == DONE);
    assign init_addr_o = iaddr_q;
    assign init_data_o = idata_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // accumulate on the edge that ends each write cycle
    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (state_q == WRITE) begin
            csum_d = csum_q + idata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (WORD_COUNT=4): stimulus queues expected writes, a forked monitor checks them.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        init_en_o;
    logic [7:0]  init_addr_o;
    logic [31:0] init_data_o;
    logic        busy_o;
    logic        done_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    imem_loader #(.WORD_COUNT(4), .ADDR_W(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .init_en_o   (init_en_o),
        .init_addr_o (init_addr_o),
        .init_data_o (init_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum_o  (checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errs   = 0;
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cycles(1);
        start_i = 1'b0;
    endtask

    // leaves rx_valid asserted so consecutive calls stream back-to-back
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 50) begin
            cycles(1);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: rx_ready stayed 0 for byte 0x%02h", b);
        end
        cycles(1);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        rx_valid_i = 1'b0;
        cycles(1);
    endtask

    task automatic do_reset();
        rx_valid_i = 1'b0;
        start_i    = 1'b0;
        reset_i    = 1'b1;
        cycles(2);
        reset_i    = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;

        fork
            forever begin
                @(negedge clk_i);
                if (init_en_o === 1'b1) begin
                    chk("no_ready_during_write", {31'd0, rx_ready_o}, 32'd0);
                    if (exp_addr.size() == 0) begin
                        chk("stray_init_en", 32'd1, 32'd0);
                    end else begin
                        chk("wr_addr", {24'd0, init_addr_o}, {24'd0, exp_addr.pop_front()});
                        chk("wr_data", init_data_o, exp_data.pop_front());
                    end
                end
            end
        join_none

        // reset state, with start and rx_valid asserted to confirm reset priority
        start_i    = 1'b1;
        rx_valid_i = 1'b1;
        cycles(3);
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        reset_i    = 1'b0;
        chk("rst_rx_ready",  {31'd0, rx_ready_o}, 32'd0);
        chk("rst_init_en",   {31'd0, init_en_o},  32'd0);
        chk("rst_busy",      {31'd0, busy_o},     32'd0);
        chk("rst_done",      {31'd0, done_o},     32'd0);
        chk("rst_init_addr", {24'd0, init_addr_o}, 32'd0);
        chk("rst_init_data", init_data_o, 32'd0);

        // single word, latency of init_en after fourth byte
        pulse_start();
        chk("start_busy", {31'd0, busy_o}, 32'd1);
        expect_wr(8'h00, 32'h0000_0013);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        chk("write_latency", {31'd0, init_en_o}, 32'd1);
        rx_valid_i = 1'b0;
        cycles(2);
        do_reset();

        // full session, contiguous bytes
        pulse_start();
        expect_wr(8'h00, 32'h0302_0100);
        expect_wr(8'h01, 32'h0706_0504);
        expect_wr(8'h02, 32'h0B0A_0908);
        expect_wr(8'h03, 32'h0F0E_0D0C);
        for (int i = 0; i < 16; i++) send(8'(i));
        rx_valid_i = 1'b0;
        cycles(2);
        chk("done_after_last", {31'd0, done_o}, 32'd1);
        chk("busy_after_last", {31'd0, busy_o}, 32'd0);
        chk("hold_addr",       {24'd0, init_addr_o}, 32'd3);
        chk("hold_data",       init_data_o, 32'h0F0E_0D0C);
        cycles(3);
        chk("done_held", {31'd0, done_o}, 32'd1);

        // restart from DONE, toggled valid, start pulsed mid-session
        pulse_start();
        chk("restart_done_drop", {31'd0, done_o}, 32'd0);
        chk("restart_busy",      {31'd0, busy_o}, 32'd1);
        expect_wr(8'h00, 32'h0302_0100);
        expect_wr(8'h01, 32'h0706_0504);
        expect_wr(8'h02, 32'h0B0A_0908);
        expect_wr(8'h03, 32'h0F0E_0D0C);
        for (int i = 0; i < 16; i++) begin
            send_gap(8'(i));
            if (i == 5) pulse_start();
        end
        cycles(2);
        chk("toggle_done", {31'd0, done_o}, 32'd1);

        // partial word retained across an idle stretch
        pulse_start();
        expect_wr(8'h00, 32'h4433_2211);
        send(8'h11); send(8'h22);
        rx_valid_i = 1'b0;
        cycles(6);
        chk("partial_wait_busy", {31'd0, busy_o}, 32'd1);
        send(8'h33); send(8'h44);
        // two bytes of word 1, then reset discards them
        send(8'h55); send(8'h66);
        do_reset();
        cycles(3);
        chk("midreset_busy", {31'd0, busy_o}, 32'd0);
        pulse_start();
        expect_wr(8'h00, 32'hDDCC_BBAA);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        rx_valid_i = 1'b0;
        cycles(3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        chk("csum_reset", checksum_o, 32'd0);
        pulse_start();
        expect_wr(8'h00, 32'hFFFF_FFFF);
        expect_wr(8'h01, 32'h0000_0002);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        rx_valid_i = 1'b0;
        cycles(2);
        chk("csum_wrap", checksum_o, 32'h0000_0001);
        do_reset();
        chk("csum_cleared", checksum_o, 32'd0);
`endif

        cycles(2);
        chk("scoreboard_empty", exp_addr.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
